// File: rtl/slos_seq_ctrl.sv
// SLOS transmit sequencer for Gen2/Gen3 lane init: SLOS1 phase, then SLOS2 phase, then done.
// Latency: every output is registered; a change appears one clk after the input that caused it.
// Backpressure: none; slos_sent and partner detects are single-cycle pulses consumed when they occur.
module slos_seq_ctrl #(
    parameter int MIN_SLOS1 = 2,
    parameter int MIN_SLOS2 = 2,
    parameter int MAX_SLOS  = 1024,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             slos_sent,
    input  logic             partner_slos1_det,
    input  logic             partner_slos2_det,
    output logic             slos_en,
    output logic             slos1_slos2,
    output logic             done,
    output logic             timeout_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] slos_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SLOS1 = 3'd1,
        SLOS2 = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MIN1_C = CNT_W'(MIN_SLOS1);
    localparam logic [CNT_W-1:0] MIN2_C = CNT_W'(MIN_SLOS2);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_SLOS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             p1_q, p1_d;
    logic             p2_q, p2_d;
    logic             en_q, en_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Register the state, counter, partner latches and every output together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            en_q    <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state and next registered outputs; outputs default low and each state raises its own.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        en_d    = 1'b0;
        sel_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // Saturate so the counter can never wrap even if MAX is somehow exceeded.
        cnt_inc = (cnt_q >= MAX_C) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                p1_d  = 1'b0;
                p2_d  = 1'b0;
                if (start) begin
                    state_d = SLOS1;
                    en_d    = 1'b1;
                end
            end
            SLOS1: begin
                en_d = 1'b1;
                if (partner_slos1_det) begin
                    p1_d = 1'b1;
                end
                // Decisions are taken only on a completed set, so the select flips on a boundary.
                if (slos_sent) begin
                    if ((cnt_inc >= MIN1_C) && (p1_q || partner_slos1_det)) begin
                        state_d = SLOS2;
                        sel_d   = 1'b1;
                        cnt_d   = '0;
                        p1_d    = 1'b0;
                        p2_d    = 1'b0;   // SLOS2 detects seen during SLOS1 are stale
                    end else if (cnt_inc == MAX_C) begin
                        state_d = ERR;
                        en_d    = 1'b0;
                        err_d   = 1'b1;
                        cnt_d   = MAX_C;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            SLOS2: begin
                en_d  = 1'b1;
                sel_d = 1'b1;
                if (partner_slos2_det) begin
                    p2_d = 1'b1;
                end
                if (slos_sent) begin
                    if ((cnt_inc >= MIN2_C) && (p2_q || partner_slos2_det)) begin
                        state_d = DONE;
                        en_d    = 1'b0;
                        sel_d   = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        p2_d    = 1'b0;
                    end else if (cnt_inc == MAX_C) begin
                        state_d = ERR;
                        en_d    = 1'b0;
                        sel_d   = 1'b0;
                        err_d   = 1'b1;
                        cnt_d   = MAX_C;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
                cnt_d  = '0;
            end
            ERR: begin
                err_d = 1'b1;   // counter stays frozen at MAX
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                p1_d    = 1'b0;
                p2_d    = 1'b0;
            end
        endcase

        // Dropping start aborts from anywhere and outranks exit and timeout.
        if (!start) begin
            state_d = IDLE;
            cnt_d   = '0;
            p1_d    = 1'b0;
            p2_d    = 1'b0;
            en_d    = 1'b0;
            sel_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    assign slos_en     = en_q;
    assign slos1_slos2 = sel_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign state       = state_q;
    assign slos_cnt    = cnt_q;

endmodule

// File: tb/tb_slos_seq_ctrl.sv
// Testbench for slos_seq_ctrl: one instance with default limits, one with MAX_SLOS=8.
// Latency: each step drives inputs, waits one clk edge, samples 1 time unit later.
// Backpressure: none; expectations are queued per step and popped when the edge result is sampled.
module tb_slos_seq_ctrl;

    localparam int CNT_W = 11;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic slos_sent;
    logic partner_slos1_det;
    logic partner_slos2_det;

    logic             en_a, sel_a, done_a, err_a;
    logic [2:0]       state_a;
    logic [CNT_W-1:0] cnt_a;
    logic             en_b, sel_b, done_b, err_b;
    logic [2:0]       state_b;
    logic [CNT_W-1:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         which;
        logic [2:0] st;
        logic       en;
        logic       sel;
        logic       dn;
        logic       er;
        int         cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    slos_seq_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .slos_sent         (slos_sent),
        .partner_slos1_det (partner_slos1_det),
        .partner_slos2_det (partner_slos2_det),
        .slos_en           (en_a),
        .slos1_slos2       (sel_a),
        .done              (done_a),
        .timeout_err       (err_a),
        .state             (state_a),
        .slos_cnt          (cnt_a)
    );

    slos_seq_ctrl #(.MAX_SLOS(8)) dut8 (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .slos_sent         (slos_sent),
        .partner_slos1_det (partner_slos1_det),
        .partner_slos2_det (partner_slos2_det),
        .slos_en           (en_b),
        .slos1_slos2       (sel_b),
        .done              (done_b),
        .timeout_err       (err_b),
        .state             (state_b),
        .slos_cnt          (cnt_b)
    );

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the selected instance.
    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (e.which == 0) begin
            check_val({e.tag, ".state"}, int'(state_a), int'(e.st));
            check_val({e.tag, ".slos_en"}, int'(en_a), int'(e.en));
            check_val({e.tag, ".sel"}, int'(sel_a), int'(e.sel));
            check_val({e.tag, ".done"}, int'(done_a), int'(e.dn));
            check_val({e.tag, ".timeout"}, int'(err_a), int'(e.er));
            check_val({e.tag, ".cnt"}, int'(cnt_a), e.cnt);
        end else begin
            check_val({e.tag, ".state"}, int'(state_b), int'(e.st));
            check_val({e.tag, ".slos_en"}, int'(en_b), int'(e.en));
            check_val({e.tag, ".sel"}, int'(sel_b), int'(e.sel));
            check_val({e.tag, ".done"}, int'(done_b), int'(e.dn));
            check_val({e.tag, ".timeout"}, int'(err_b), int'(e.er));
            check_val({e.tag, ".cnt"}, int'(cnt_b), e.cnt);
        end
    endtask

    // in = {reset, start, slos_sent, det1, det2}; expectation is for the state after the next edge.
    task automatic step(input logic [4:0] in, input int which, input logic [2:0] st,
                        input logic en, input logic sel, input logic dn, input logic er,
                        input int cnt, input string tag);
        exp_t e;
        {reset, start, slos_sent, partner_slos1_det, partner_slos2_det} = in;
        e.which = which; e.st = st; e.en = en; e.sel = sel;
        e.dn = dn; e.er = er; e.cnt = cnt; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    localparam logic [2:0] S_IDLE = 3'd0, S_S1 = 3'd1, S_S2 = 3'd2, S_DN = 3'd3, S_ER = 3'd4;

    initial begin
        reset = 1'b0; start = 1'b0; slos_sent = 1'b0;
        partner_slos1_det = 1'b0; partner_slos2_det = 1'b0;

        // Reset state on both instances
        step(5'b00000, 0, S_IDLE, 0, 0, 0, 0, 0, "reset_a");
        step(5'b00000, 1, S_IDLE, 0, 0, 0, 0, 0, "reset_b");
        step(5'b10000, 0, S_IDLE, 0, 0, 0, 0, 0, "idle_nostart");

        // Nominal sequence
        step(5'b11000, 0, S_S1, 1, 0, 0, 0, 0, "nom_s1_entry");
        step(5'b11010, 0, S_S1, 1, 0, 0, 0, 0, "nom_det1");
        step(5'b11100, 0, S_S1, 1, 0, 0, 0, 1, "nom_sent1");
        step(5'b11100, 0, S_S2, 1, 1, 0, 0, 0, "nom_to_s2");
        step(5'b11001, 0, S_S2, 1, 1, 0, 0, 0, "nom_det2");
        step(5'b11100, 0, S_S2, 1, 1, 0, 0, 1, "nom_s2_sent1");
        step(5'b11100, 0, S_DN, 0, 0, 1, 0, 0, "nom_done");
        step(5'b11100, 0, S_DN, 0, 0, 1, 0, 0, "nom_done_held");
        step(5'b10000, 0, S_IDLE, 0, 0, 0, 0, 0, "nom_release");

        // Late partner: ten sets with no detect, exit on the eleventh with detect
        step(5'b11000, 0, S_S1, 1, 0, 0, 0, 0, "late_entry");
        for (int i = 1; i <= 10; i++) begin
            step(5'b11100, 0, S_S1, 1, 0, 0, 0, i, "late_wait");
        end
        step(5'b11110, 0, S_S2, 1, 1, 0, 0, 0, "late_exit");

        // Abort mid-SLOS2 at count 3
        for (int i = 1; i <= 3; i++) begin
            step(5'b11100, 0, S_S2, 1, 1, 0, 0, i, "abort_count");
        end
        step(5'b10000, 0, S_IDLE, 0, 0, 0, 0, 0, "abort_idle");

        // Reset mid-SLOS1, then restart needs a fresh detect
        step(5'b11000, 0, S_S1, 1, 0, 0, 0, 0, "rst_entry");
        step(5'b11010, 0, S_S1, 1, 0, 0, 0, 0, "rst_det1");
        step(5'b11100, 0, S_S1, 1, 0, 0, 0, 1, "rst_sent1");
        step(5'b01000, 0, S_IDLE, 0, 0, 0, 0, 0, "rst_mid_s1");
        step(5'b11000, 0, S_S1, 1, 0, 0, 0, 0, "rst_restart");
        step(5'b11100, 0, S_S1, 1, 0, 0, 0, 1, "rst_p1_clear1");
        step(5'b11100, 0, S_S1, 1, 0, 0, 0, 2, "rst_p1_clear2");
        step(5'b11110, 0, S_S2, 1, 1, 0, 0, 0, "rst_fresh_det");

        // Stale SLOS2 detect during SLOS1 must not count
        step(5'b10000, 0, S_IDLE, 0, 0, 0, 0, 0, "stale_idle");
        step(5'b11000, 0, S_S1, 1, 0, 0, 0, 0, "stale_entry");
        step(5'b11001, 0, S_S1, 1, 0, 0, 0, 0, "stale_det2_in_s1");
        step(5'b11110, 0, S_S1, 1, 0, 0, 0, 1, "stale_sent1");
        step(5'b11100, 0, S_S2, 1, 1, 0, 0, 0, "stale_to_s2");
        step(5'b11100, 0, S_S2, 1, 1, 0, 0, 1, "stale_s2_1");
        step(5'b11100, 0, S_S2, 1, 1, 0, 0, 2, "stale_no_exit");
        step(5'b11101, 0, S_DN, 0, 0, 1, 0, 0, "stale_new_det");

        // Timeout on the MAX_SLOS=8 instance
        step(5'b10000, 1, S_IDLE, 0, 0, 0, 0, 0, "to_idle");
        step(5'b11000, 1, S_S1, 1, 0, 0, 0, 0, "to_entry");
        for (int i = 1; i <= 7; i++) begin
            step(5'b11100, 1, S_S1, 1, 0, 0, 0, i, "to_count");
        end
        step(5'b11100, 1, S_ER, 0, 0, 0, 1, 8, "to_err");
        step(5'b11100, 1, S_ER, 0, 0, 0, 1, 8, "to_err_frozen");
        step(5'b10000, 1, S_IDLE, 0, 0, 0, 0, 0, "to_abort");

        // Exit and timeout in the same cycle: exit wins
        step(5'b11000, 1, S_S1, 1, 0, 0, 0, 0, "tie_entry");
        for (int i = 1; i <= 7; i++) begin
            step(5'b11100, 1, S_S1, 1, 0, 0, 0, i, "tie_count");
        end
        step(5'b11110, 1, S_S2, 1, 1, 0, 0, 0, "tie_exit_wins");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
